// File: rtl/ctrl_mc.sv
// Multi-cycle control sequencer for the SISC datapath (FETCH/DECODE/EXECUTE/MEM/WB).
// Optional SWP support: define CTRL_SWP_EN to enable the two-cycle swap writeback (WB, WB2).
module ctrl_mc #(
  parameter int OPW         = 4,
  parameter int MMW         = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_f,
  input  logic [OPW-1:0] opcode,
  input  logic [MMW-1:0] mm,
  input  logic [MMW-1:0] stat,
  input  logic           dm_ack,
  output logic           ir_load,
  output logic           pc_write,
  output logic [1:0]     pc_sel,
  output logic [1:0]     alu_op,
  output logic           rf_we,
  output logic [1:0]     wb_sel,
  output logic           dm_req,
  output logic           dm_we,
  output logic           halted,
  output logic           err,
  output logic [3:0]     state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPW-1:0] OP_LOD = OPW'(1);
  localparam logic [OPW-1:0] OP_STR = OPW'(2);
  localparam logic [OPW-1:0] OP_SWP = OPW'(3);
  localparam logic [OPW-1:0] OP_BRA = OPW'(4);
  localparam logic [OPW-1:0] OP_BRR = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE = OPW'(6);
  localparam logic [OPW-1:0] OP_BNR = OPW'(7);
  localparam logic [OPW-1:0] OP_ALU = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  typedef enum logic [3:0] {
    S_START0  = 4'd0,
    S_START1  = 4'd1,
    S_FETCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_EXECUTE = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_WB2     = 4'd7,
    S_HALT    = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;

  logic is_mem, is_swp, cond_hit, timeout_hit;

  assign is_mem      = (opcode == OP_LOD) || (opcode == OP_STR);
  assign cond_hit    = |(stat & mm);
  assign timeout_hit = (cnt_q == CW'(MEM_TIMEOUT - 1));

`ifdef CTRL_SWP_EN
  assign is_swp = (opcode == OP_SWP);
`else
  assign is_swp = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_START1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Held at zero outside MEM, so it is always clear on entry.
      if (state_q != S_MEM)  cnt_q <= '0;
      else if (!dm_ack)      cnt_q <= cnt_q + CW'(1);
    end
  end

  // NOTE: every output and state_d gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 2'b00;
    alu_op   = 2'b00;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;

    unique case (state_q)
      S_START0: state_d = S_START1;
      S_START1: state_d = S_FETCH;

      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end

      S_DECODE: state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;

      S_EXECUTE: begin
        if (opcode == OP_ALU)  alu_op = {1'b0, mm == MMW'(8)};
        else if (is_mem)       alu_op = 2'b11;
        else                   alu_op = 2'b10;

        if (((opcode == OP_BRA || opcode == OP_BRR) && cond_hit) ||
            ((opcode == OP_BNE || opcode == OP_BNR) && !cond_hit)) begin
          pc_write = 1'b1;
          pc_sel   = (opcode == OP_BRA || opcode == OP_BNE) ? 2'b01 : 2'b10;
        end
        state_d = S_MEM;
      end

      S_MEM: begin
        if (is_mem) begin
          dm_req = 1'b1;
          dm_we  = (opcode == OP_STR);
          // An ack on the last permitted cycle takes priority over the trap.
          if (dm_ack)            state_d = S_WB;
          else if (timeout_hit)  state_d = S_ERR;
        end else begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        if (opcode == OP_ALU) begin
          rf_we  = 1'b1;
          wb_sel = 2'b00;
        end else if (opcode == OP_LOD) begin
          rf_we  = 1'b1;
          wb_sel = 2'b01;
        end else if (is_swp) begin
          rf_we  = 1'b1;
          wb_sel = 2'b11;
        end else begin
          wb_sel = 2'b10;
        end
        state_d = is_swp ? S_WB2 : S_FETCH;
      end

      S_WB2: begin
`ifdef CTRL_SWP_EN
        rf_we  = 1'b1;
        wb_sel = 2'b11;
`endif
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;
      S_ERR:  err    = 1'b1;

      default: state_d = S_START1;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_mc.sv
// Self-checking bench for ctrl_mc: per-instruction expected output traces from a cycle-level model.
// Honours CTRL_SWP_EN the same way as the design.
module tb_ctrl_mc;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       dm_ack;
  logic       ir_load, pc_write, rf_we, dm_req, dm_we, halted, err;
  logic [1:0] pc_sel, alu_op, wb_sel;
  logic [3:0] state;

  ctrl_mc #(.OPW(4), .MMW(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .dm_ack(dm_ack),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .alu_op(alu_op),
    .rf_we(rf_we), .wb_sel(wb_sel), .dm_req(dm_req), .dm_we(dm_we),
    .halted(halted), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       dm_req;
    logic       dm_we;
    logic       halted;
    logic       err;
  } obs_t;

  obs_t q_exp[$];
  logic q_ack[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t blank(input logic [3:0] st);
    obs_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic obs_t observe();
    return {state, ir_load, pc_write, pc_sel, alu_op, rf_we, wb_sel, dm_req, dm_we, halted, err};
  endfunction

  // Expected cycle-by-cycle trace of one instruction starting in FETCH.
  // ack_delay = number of MEM cycles without ack before the acked one; >= TO means never.
  task automatic build(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                       input int ack_delay);
    obs_t e;
    bit   mem_op, swp, hit, taken;
    int   n;
    q_exp.delete();
    q_ack.delete();
    mem_op = (op == 1) || (op == 2);
`ifdef CTRL_SWP_EN
    swp = (op == 3);
`else
    swp = 1'b0;
`endif
    hit = (s & m) != 0;
    taken = ((op == 4 || op == 5) && hit) || ((op == 6 || op == 7) && !hit);

    e = blank(2); e.ir_load = 1; e.pc_write = 1;
    q_exp.push_back(e); q_ack.push_back(1'($urandom_range(0, 1)));
    q_exp.push_back(blank(3)); q_ack.push_back(1'($urandom_range(0, 1)));

    if (op == 15) begin
      e = blank(8); e.halted = 1;
      repeat (4) begin q_exp.push_back(e); q_ack.push_back(1'($urandom_range(0, 1))); end
      return;
    end

    e = blank(4);
    e.alu_op = (op == 8) ? {1'b0, m == 4'b1000} : (mem_op ? 2'b11 : 2'b10);
    if (taken) begin
      e.pc_write = 1;
      e.pc_sel   = (op == 4 || op == 6) ? 2'b01 : 2'b10;
    end
    q_exp.push_back(e); q_ack.push_back(1'($urandom_range(0, 1)));

    if (mem_op) begin
      n = (ack_delay < TO) ? ack_delay + 1 : TO;
      for (int i = 0; i < n; i++) begin
        e = blank(5); e.dm_req = 1; e.dm_we = (op == 2);
        q_exp.push_back(e); q_ack.push_back(i == ack_delay);
      end
      if (ack_delay >= TO) begin
        e = blank(9); e.err = 1;
        repeat (4) begin q_exp.push_back(e); q_ack.push_back(1'($urandom_range(0, 1))); end
        return;
      end
    end else begin
      q_exp.push_back(blank(5)); q_ack.push_back(1'($urandom_range(0, 1)));
    end

    e = blank(6);
    if (op == 8)      begin e.rf_we = 1; e.wb_sel = 2'b00; end
    else if (op == 1) begin e.rf_we = 1; e.wb_sel = 2'b01; end
    else if (swp)     begin e.rf_we = 1; e.wb_sel = 2'b11; end
    else              e.wb_sel = 2'b10;
    q_exp.push_back(e); q_ack.push_back(1'($urandom_range(0, 1)));
    if (swp) begin
      e = blank(7); e.rf_we = 1; e.wb_sel = 2'b11;
      q_exp.push_back(e); q_ack.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // Asserts rst_f mid-cycle, checks the immediate effect, releases it on a falling edge.
  task automatic do_reset(input string name);
    obs_t act;
    @(negedge clk);
    #2 rst_f = 1'b0;
    #1 act = observe();
    checks++;
    if (act !== blank(1)) begin
      errors++;
      $display("FAIL %s reset_assert: got %h expected %h", name, act, blank(1));
    end
    @(negedge clk);
    rst_f = 1'b1;
    #1 act = observe();
    checks++;
    if (act !== blank(1)) begin
      errors++;
      $display("FAIL %s reset_release: got %h expected %h", name, act, blank(1));
    end
  endtask

  // Drives one instruction and compares every cycle; abort_at >= 0 cuts it short with a reset.
  task automatic run_instr(input string name, input logic [3:0] op, input logic [3:0] m,
                           input logic [3:0] s, input int ack_delay, input int abort_at);
    obs_t act;
    int   len;
    bit   terminal;
    build(op, m, s, ack_delay);
    len      = q_exp.size();
    terminal = q_exp[len-1].halted || q_exp[len-1].err;
    if (abort_at >= 0 && abort_at < len) len = abort_at;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      opcode = op; mm = m; stat = s; dm_ack = q_ack[i];
      #1 act = observe();
      checks++;
      if (act !== q_exp[i]) begin
        errors++;
        $display("FAIL %s op%0d cyc%0d: got %h expected %h", name, op, i, act, q_exp[i]);
      end
    end
    if (terminal || abort_at >= 0) do_reset(name);
  endtask

  task automatic test_reset();
    obs_t act;
    rst_f = 1'b0; opcode = '0; mm = '0; stat = '0; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    act = observe();
    checks++;
    if (act !== blank(1)) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", act, blank(1));
    end
    rst_f = 1'b1;
  endtask

  task automatic test_alu();
    run_instr("alu_add", 4'd8, 4'b0000, 4'($urandom), 0, -1);
    run_instr("adi", 4'd8, 4'b1000, 4'($urandom), 0, -1);
    run_instr("after_adi", 4'd0, 4'($urandom), 4'($urandom), 0, -1);
  endtask

  task automatic test_branch();
    run_instr("brr_taken", 4'd5, 4'b0010, 4'b0010, 0, -1);
    run_instr("brr_not", 4'd5, 4'b0010, 4'b0000, 0, -1);
    run_instr("bne_taken", 4'd6, 4'b0001, 4'b0000, 0, -1);
    run_instr("bra_taken", 4'd4, 4'b1100, 4'b0100, 0, -1);
    run_instr("bnr_not", 4'd7, 4'b1000, 4'b1001, 0, -1);
  endtask

  task automatic test_mem();
    run_instr("lod_delay3", 4'd1, 4'($urandom), 4'($urandom), 3, -1);
    run_instr("str_ack_last", 4'd2, 4'($urandom), 4'($urandom), TO - 1, -1);
    run_instr("str_timeout", 4'd2, 4'($urandom), 4'($urandom), 1000, -1);
    run_instr("lod_timeout", 4'd1, 4'($urandom), 4'($urandom), 1000, -1);
  endtask

  task automatic test_halt();
    run_instr("hlt", 4'd15, 4'($urandom), 4'($urandom), 0, -1);
  endtask

  task automatic test_reset_mid_mem();
    run_instr("rst_mid_mem", 4'd1, 4'($urandom), 4'($urandom), 1000, 6);
    run_instr("after_rst", 4'd8, 4'b0000, 4'($urandom), 0, -1);
  endtask

  task automatic test_swp();
    run_instr("swp", 4'd3, 4'($urandom), 4'($urandom), 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_instr("b2b", (i % 2 == 0) ? 4'd1 : 4'd2, 4'($urandom), 4'($urandom), 0, -1);
  endtask

  task automatic test_random();
    logic [3:0] op;
    int         dly;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      if (op == 4'd15 && ($urandom_range(0, 3) != 0)) op = 4'd8;
      case ($urandom_range(0, 9))
        0:       dly = TO - 1;
        1:       dly = TO + 5;
        default: dly = $urandom_range(0, 5);
      endcase
      run_instr("random", op, 4'($urandom), 4'($urandom), dly, -1);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_halt();
    test_reset_mid_mem();
    test_swp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
